serial_perm_ctrl: RTL and testbench

- Parametrised successor controller for the serial 320-bit (5 x 64-bit lane) permutation datapath.
- Replaces the fixed 1-bit FSM that depended on an external bit counter and iteration counter. This block owns the slice counter, the round counter and round-constant generation.
- Supports a configurable slice width (bits per cycle), 1..12 rounds per invocation, optional state load, abort, and a start/ready/done handshake.
- Sits between the mode-level controller (AEAD/hash sequencer) and the lane shift registers, S-box and linear-layer temp register.

---
 rtl/perm_pkg.sv | 49 ++++
 rtl/perm_slice_counter.sv | 40 ++++
 rtl/serial_perm_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_perm_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
// Shared types and helpers for the serial 320-bit permutation controller.
// Phase encoding, lane-mux encodings and the per-phase lane control table.
package perm_pkg;

    localparam int LANE_W  = 64;
    localparam int CONST_W = 8;

    localparam logic [1:0] SEL_PASS  = 2'b00;
    localparam logic [1:0] SEL_CONST = 2'b01;
    localparam logic [1:0] SEL_SBOX  = 2'b11;
    localparam logic [1:0] SEL_LIN   = 2'b10;

    // Round phases are listed in execution order; the FSM advances by +1 within a round.
    typedef enum logic [3:0] {
        PH_IDLE, PH_LOAD, PH_PC_HI, PH_PC_LO, PH_SBOX,
        PH_LX0, PH_LX1, PH_LX2, PH_LX3_HI, PH_LX3_LO, PH_LX4, PH_LFIN
    } phase_e;

    typedef struct packed {
        logic [1:0] state_sel;
        logic [4:0] enable;
        logic       temp_enable;
        logic [2:0] temp_sel;
    } lane_ctrl_t;

    function automatic logic [CONST_W-1:0] round_const(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic lane_ctrl_t phase_ctrl(input phase_e ph);
        lane_ctrl_t c;
        c = '0;
        case (ph)
            PH_LOAD, PH_PC_HI: c = '{SEL_PASS,  5'b11111, 1'b0, 3'b000};
            PH_PC_LO:          c = '{SEL_CONST, 5'b11111, 1'b0, 3'b000};
            PH_SBOX:           c = '{SEL_SBOX,  5'b11111, 1'b0, 3'b000};
            PH_LX0:            c = '{SEL_LIN,   5'b10000, 1'b1, 3'b000};
            PH_LX1:            c = '{SEL_LIN,   5'b11000, 1'b1, 3'b001};
            PH_LX2:            c = '{SEL_LIN,   5'b01100, 1'b1, 3'b011};
            PH_LX3_HI:         c = '{SEL_LIN,   5'b00110, 1'b1, 3'b010};
            PH_LX3_LO:         c = '{SEL_LIN,   5'b00110, 1'b1, 3'b110};
            PH_LX4:            c = '{SEL_LIN,   5'b00011, 1'b1, 3'b111};
            PH_LFIN:           c = '{SEL_LIN,   5'b00001, 1'b1, 3'b101};
            default:           c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/perm_slice_counter.sv
// Wrapping slice counter: runs over 0..len_m1 (or len_m1..0 when COUNT_DOWN)
// and flags the final slice of the current phase.
module perm_slice_counter #(
    parameter int CNT_W      = 6,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] len_m1,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;

    generate
        if (COUNT_DOWN) begin : g_down
            always_ff @(posedge clk) begin
                if (rst || clr)
                    cnt_reg <= len_m1;
                else if (en)
                    cnt_reg <= (cnt_reg == '0) ? len_m1 : cnt_reg - CNT_W'(1);
            end
            assign last = (cnt_reg == '0);
        end else begin : g_up
            always_ff @(posedge clk) begin
                if (rst || clr)
                    cnt_reg <= '0;
                else if (en)
                    cnt_reg <= (cnt_reg == len_m1) ? '0 : cnt_reg + CNT_W'(1);
            end
            assign last = (cnt_reg == len_m1);
        end
    endgenerate

    assign cnt = cnt_reg;

endmodule

// File: rtl/serial_perm_ctrl.sv
// Round/phase sequencer for the serial 5x64-bit permutation datapath: owns the
// slice and round counters, drives lane enables/muxes and the round constant.
module serial_perm_ctrl
    import perm_pkg::*;
#(
    parameter int SLICE_W    = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_load,
    input  logic [3:0] cfg_rounds,
    input  logic       abort,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_sel,
    output logic [4:0] enable,
    output logic       temp_enable,
    output logic [2:0] temp_sel,
    output logic [3:0] round_idx,
    output logic [7:0] rc,
    output logic [5:0] slice_cnt
);

    generate
        if (SLICE_W != 1 && SLICE_W != 2 && SLICE_W != 4 && SLICE_W != 8) begin : g_bad_slice_w
            $error("serial_perm_ctrl: SLICE_W must be 1, 2, 4 or 8");
        end
        if (MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_max_rounds
            $error("serial_perm_ctrl: MAX_ROUNDS must be 1..15");
        end
    endgenerate

    localparam int L = LANE_W / SLICE_W;
    localparam int H = (LANE_W - 8) / SLICE_W;
    localparam logic [5:0] FULL_M1 = 6'(L - 1);
    localparam logic [5:0] HI_M1   = 6'(H - 1);
    localparam logic [5:0] LO_M1   = 6'(L - H - 1);
    localparam logic [3:0] MAX_R   = 4'(MAX_ROUNDS);

    phase_e     state_reg, state_next;
    logic [3:0] round_idx_reg, round_idx_next;
    logic [3:0] rounds_reg, rounds_next;
    logic       done_reg, done_next;
    logic [5:0] len_m1;
    logic       slice_last;
    logic [3:0] rc_i;
    lane_ctrl_t ctrl;

    perm_slice_counter #(.CNT_W(6), .COUNT_DOWN(1'b0)) u_slice_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort || (state_reg == PH_IDLE)),
        .en     (state_reg != PH_IDLE),
        .len_m1 (len_m1),
        .cnt    (slice_cnt),
        .last   (slice_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= PH_IDLE;
            round_idx_reg <= '0;
            rounds_reg    <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            round_idx_reg <= round_idx_next;
            rounds_reg    <= rounds_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        round_idx_next = round_idx_reg;
        rounds_next    = rounds_reg;
        done_next      = 1'b0;
        case (state_reg)
            PH_PC_HI, PH_LX3_HI: len_m1 = HI_M1;
            PH_PC_LO, PH_LX3_LO: len_m1 = LO_M1;
            default:             len_m1 = FULL_M1;
        endcase

        if (state_reg == PH_IDLE) begin
            if (start) begin
                // Zero or out-of-range round counts run the full schedule.
                rounds_next = (cfg_rounds == 4'd0 || cfg_rounds > MAX_R) ? MAX_R : cfg_rounds;
                state_next  = cfg_load ? PH_LOAD : PH_PC_HI;
            end
        end else if (slice_last) begin
            if (state_reg == PH_LFIN) begin
                if (round_idx_reg == rounds_reg - 4'd1) begin
                    state_next     = PH_IDLE;
                    round_idx_next = '0;
                    done_next      = 1'b1;
                end else begin
                    state_next     = PH_PC_HI;
                    round_idx_next = round_idx_reg + 4'd1;
                end
            end else begin
                state_next = phase_e'(state_reg + 4'd1);
            end
        end

        if (abort) begin
            state_next     = PH_IDLE;
            round_idx_next = '0;
            done_next      = 1'b0;
        end
    end

    assign ctrl        = phase_ctrl(state_reg);
    assign state_sel   = ctrl.state_sel;
    assign enable      = ctrl.enable;
    assign temp_enable = ctrl.temp_enable;
    assign temp_sel    = ctrl.temp_sel;

    assign ready     = (state_reg == PH_IDLE);
    assign busy      = (state_reg != PH_IDLE);
    assign done      = done_reg;
    assign round_idx = round_idx_reg;
    // Short runs use the tail of the constant schedule so the last round is always i = MAX_ROUNDS-1.
    assign rc_i      = MAX_R - rounds_reg + round_idx_reg;
    assign rc        = busy ? round_const(rc_i) : '0;

endmodule

// File: tb/tb_serial_perm_ctrl.sv
// Bench for serial_perm_ctrl: SLICE_W=1 and SLICE_W=8 instances share stimulus and are
// compared every cycle against a cycle-offset model of the permutation schedule.
module tb_serial_perm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_rounds = 4'd0;
    logic       abort = 1'b0;

    logic       ready [2];
    logic       busy [2];
    logic       done [2];
    logic       temp_enable [2];
    logic [1:0] state_sel [2];
    logic [4:0] enable [2];
    logic [2:0] temp_sel [2];
    logic [3:0] round_idx [2];
    logic [7:0] rc [2];
    logic [5:0] slice_cnt [2];
    logic [31:0] dut_out [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        serial_perm_ctrl #(.SLICE_W(gi == 0 ? 1 : 8), .MAX_ROUNDS(12)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .cfg_load    (cfg_load),
            .cfg_rounds  (cfg_rounds),
            .abort       (abort),
            .ready       (ready[gi]),
            .busy        (busy[gi]),
            .done        (done[gi]),
            .state_sel   (state_sel[gi]),
            .enable      (enable[gi]),
            .temp_enable (temp_enable[gi]),
            .temp_sel    (temp_sel[gi]),
            .round_idx   (round_idx[gi]),
            .rc          (rc[gi]),
            .slice_cnt   (slice_cnt[gi])
        );
        assign dut_out[gi] = {ready[gi], busy[gi], done[gi], state_sel[gi], enable[gi],
                              temp_enable[gi], temp_sel[gi], round_idx[gi], rc[gi], slice_cnt[gi]};
    end

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int sw_of(input int k);
        return (k == 0) ? 1 : 8;
    endfunction

    function automatic int sat_rounds(input logic [3:0] r);
        return (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
    endfunction

    // Expected output bundle at cycle offset t of a busy period.
    function automatic logic [31:0] exp_outs(input int sw, input bit act, input bit dn,
                                             input bit ld, input int nr, input int t);
        int lw, hw, u, r, s, lx;
        logic [1:0] ss;
        logic [4:0] en;
        logic       te;
        logic [2:0] ts;
        logic [3:0] ci;
        lw = 64 / sw;
        hw = 56 / sw;
        if (!act) return {1'b1, 1'b0, dn, 29'd0};
        r = 0; s = 0; ss = 2'b00; en = 5'b11111; te = 1'b0; ts = 3'b000;
        u = ld ? t - lw : t;
        if (ld && t < lw) begin
            s = t;
        end else begin
            r = u / (8 * lw);
            u = u % (8 * lw);
            if (u < hw) s = u;
            else if (u < lw) begin ss = 2'b01; s = u - hw; end
            else if (u < 2 * lw) begin ss = 2'b11; s = u - lw; end
            else begin
                ss = 2'b10; te = 1'b1;
                lx = (u - 2 * lw) / lw;
                s  = (u - 2 * lw) % lw;
                case (lx)
                    0: begin en = 5'b10000; ts = 3'b000; end
                    1: begin en = 5'b11000; ts = 3'b001; end
                    2: begin en = 5'b01100; ts = 3'b011; end
                    3: begin
                        en = 5'b00110;
                        if (s < hw) ts = 3'b010;
                        else begin ts = 3'b110; s = s - hw; end
                    end
                    4: begin en = 5'b00011; ts = 3'b111; end
                    default: begin en = 5'b00001; ts = 3'b101; end
                endcase
            end
        end
        ci = 4'(12 - nr + r);
        return {1'b0, 1'b1, 1'b0, ss, en, te, ts, 4'(r), 4'hF - ci, ci, 6'(s)};
    endfunction

    bit m_act [2] = '{1'b0, 1'b0};
    bit m_done [2] = '{1'b0, 1'b0};
    bit m_ld [2] = '{1'b0, 1'b0};
    int m_rounds [2] = '{0, 0};
    int m_t [2] = '{0, 0};
    int m_n [2] = '{0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || abort) begin
                m_act[k]  <= 1'b0;
                m_done[k] <= 1'b0;
            end else if (m_act[k]) begin
                if (m_t[k] + 1 == m_n[k]) begin
                    m_act[k]  <= 1'b0;
                    m_done[k] <= 1'b1;
                end else begin
                    m_t[k] <= m_t[k] + 1;
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start) begin
                    m_act[k]    <= 1'b1;
                    m_t[k]      <= 0;
                    m_ld[k]     <= cfg_load;
                    m_rounds[k] <= sat_rounds(cfg_rounds);
                    m_n[k]      <= (cfg_load ? 64 / sw_of(k) : 0) + sat_rounds(cfg_rounds) * 8 * (64 / sw_of(k));
                end
            end
        end
    end

    int lat [2] = '{0, 0};
    int last_lat [2] = '{0, 0};
    int max_ridx [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    logic [7:0] rc_log [$];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check_val($sformatf("outs_w%0d", sw_of(k)), dut_out[k],
                      exp_outs(sw_of(k), m_act[k], m_done[k], m_ld[k], m_rounds[k], m_t[k]));
            if (busy[k]) begin
                if (lat[k] == 0) begin
                    max_ridx[k] = 0;
                    if (k == 1) rc_log.delete();
                end
                lat[k]++;
            end else begin
                if (done[k]) begin
                    last_lat[k] = lat[k];
                    done_cnt[k]++;
                end
                lat[k] = 0;
            end
            if (int'(round_idx[k]) > max_ridx[k]) max_ridx[k] = int'(round_idx[k]);
            if (k == 1 && busy[1] && state_sel[1] == 2'b01 && slice_cnt[1] == 6'd0)
                rc_log.push_back(rc[1]);
        end
    end

    task automatic run_perm(input bit ld, input logic [3:0] nr);
        @(negedge clk);
        cfg_load = ld; cfg_rounds = nr; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_load = 1'($urandom);
        cfg_rounds = 4'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_act[0] || m_act[1]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_val("idle_wait", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_t(input int k, input int target, input int budget);
        int n;
        n = 0;
        while (!(m_act[k] && m_t[k] == target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("offset_wait", 32'(n < budget), 32'd1);
    endtask

    task automatic report_run(input string name);
        $display("run %s lat_w1=%0d lat_w8=%0d max_ridx_w1=%0d", name, last_lat[0], last_lat[1], max_ridx[0]);
    endtask

    logic [7:0] rc_exp [6];
    int d0;

    initial begin
        rc_exp = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("reset_w1", dut_out[0], 32'h8000_0000);
        check_val("reset_w8", dut_out[1], 32'h8000_0000);

        run_perm(1'b1, 4'd12);
        wait_idle(7000);
        report_run("load_r12");
        check_val("lat_load_r12_w1", 32'(last_lat[0]), 32'd6208);
        check_val("lat_load_r12_w8", 32'(last_lat[1]), 32'd776);
        check_val("max_ridx_r12", 32'(max_ridx[0]), 32'd11);

        run_perm(1'b0, 4'd6);
        wait_idle(4000);
        report_run("r6");
        check_val("lat_r6_w1", 32'(last_lat[0]), 32'd3072);
        check_val("lat_r6_w8", 32'(last_lat[1]), 32'd384);
        check_val("rc_cnt_r6", 32'(rc_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < rc_log.size(); i++)
            check_val($sformatf("rc_r6_%0d", i), 32'(rc_log[i]), 32'(rc_exp[i]));

        run_perm(1'b0, 4'd0);
        wait_idle(7000);
        report_run("r0");
        check_val("lat_r0_w1", 32'(last_lat[0]), 32'd6144);
        check_val("max_ridx_r0", 32'(max_ridx[0]), 32'd11);

        run_perm(1'b0, 4'd15);
        wait_idle(7000);
        report_run("r15");
        check_val("lat_r15_w8", 32'(last_lat[1]), 32'd768);
        check_val("max_ridx_r15", 32'(max_ridx[0]), 32'd11);

        // Abort inside round 1's LX2 of the slow instance; the idle fast instance sees start+abort.
        run_perm(1'b0, 4'd2);
        wait_t(0, 8 * 64 + 4 * 64 + 40, 2000);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1;
        check_val("abort_ready", 32'(ready[0]), 32'd1);
        check_val("abort_no_done", 32'(done[0]), 32'd0);
        check_val("abort_start_drop", 32'(busy[1]), 32'd0);
        run_perm(1'b0, 4'd2);
        wait_idle(2000);
        report_run("after_abort");
        check_val("lat_after_abort", 32'(last_lat[0]), 32'd1024);

        // Start held high: runs chain with a single idle/done cycle between them.
        @(negedge clk);
        cfg_load = 1'b0; cfg_rounds = 4'd1; start = 1'b1;
        d0 = done_cnt[0];
        repeat (1100) @(negedge clk);
        start = 1'b0;
        wait_idle(1000);
        report_run("back_to_back");
        check_val("b2b_dones", 32'(done_cnt[0] - d0), 32'd3);

        run_perm(1'b1, 4'd3);
        wait_t(0, 64 + 64 + 10, 500);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        check_val("rst_mid_sbox", dut_out[0], 32'h8000_0000);
        wait_idle(10);
        report_run("rst_mid_sbox");

        repeat (6000) begin
            @(negedge clk);
            start      = ($urandom_range(15) == 0);
            abort      = ($urandom_range(499) == 0);
            rst        = ($urandom_range(3999) == 0);
            cfg_load   = 1'($urandom);
            cfg_rounds = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        wait_idle(7000);
        report_run("random");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
